// File: rtl/bus_cycle_unit.sv
// bus_cycle_unit: multiplexed-bus master running T1..T4 byte cycles per
// transfer, with ready-driven wait states in T3.
// Optional feature: define BUS_TIMEOUT_EN to abort stuck transfers after
// TIMEOUT_CYC consecutive wait cycles (otherwise timeout is tied low).
// Ports:
//   clk, rst (async, active-low)
//   req/we/byte_op/io_m/adr/wdata : transfer request and attributes
//   rdata/busy/done/timeout       : transfer result and status
//   bus_a/ad_o/ad_oe/ad_i         : byte address and muxed addr/data bus
//   ale/rd_n/wr_n/den_n/dtr/iom   : bus strobes; ready : low = wait
module bus_cycle_unit #(
    parameter int DATA_BYTES  = 2,
    parameter int ADDR_W      = 20,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    we,
    input  logic                    byte_op,
    input  logic                    io_m,
    input  logic [ADDR_W-1:0]       adr,
    input  logic [8*DATA_BYTES-1:0] wdata,
    output logic [8*DATA_BYTES-1:0] rdata,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [ADDR_W-1:0]       bus_a,
    output logic [7:0]              ad_o,
    output logic                    ad_oe,
    input  logic [7:0]              ad_i,
    output logic                    ale,
    output logic                    rd_n,
    output logic                    wr_n,
    output logic                    den_n,
    output logic                    dtr,
    output logic                    iom,
    input  logic                    ready
);

    localparam int IW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    if (DATA_BYTES < 1 || DATA_BYTES > 4) begin : g_bad_db
        $error("DATA_BYTES must be 1..4");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_to
        $error("TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_T4
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [ADDR_W-1:0]         r_adr;
    logic [8*DATA_BYTES-1:0]   r_wdata;
    logic                      r_we;
    logic                      r_bop;
    logic                      r_iom;
    logic [IW-1:0]             r_idx;
    logic [8*DATA_BYTES-1:0]   r_rdata;
    logic [ADDR_W-1:0]         w_bus_a;
    logic [7:0]                w_wbyte;
    logic                      w_last;
    logic                      w_load;
    logic                      w_to;
    logic                      w_to_hit;

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_wcnt;
    logic          r_to;

    // Abort on the T3 cycle that would make the wait run reach the limit.
    assign w_to_hit = (r_state == S_T3) && !ready
                   && (r_wcnt == CW'(TIMEOUT_CYC - 1));
    assign w_to     = r_to;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcnt <= '0;
            r_to   <= 1'b0;
        end else begin
            if (r_state == S_T3 && !ready && !w_to_hit)
                r_wcnt <= r_wcnt + 1'b1;
            else
                r_wcnt <= '0;
            if (w_to_hit)
                r_to <= 1'b1;
            else if (r_state == S_T4)
                r_to <= 1'b0;
        end
    end
`else
    assign w_to_hit = 1'b0;
    assign w_to     = 1'b0;
`endif

    assign w_bus_a = r_adr + ADDR_W'(r_idx);
    assign w_last  = r_bop || (r_idx == IW'(DATA_BYTES - 1));
    assign w_load  = (r_state == S_T3) && (ready || w_to_hit);
    assign rdata   = r_rdata;

    always_comb begin
        w_wbyte = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (r_idx == IW'(i))
                w_wbyte = r_wdata[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        done    = 1'b0;
        timeout = 1'b0;
        bus_a   = '0;
        ad_o    = '0;
        ad_oe   = 1'b0;
        ale     = 1'b0;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        den_n   = 1'b1;
        dtr     = 1'b1;
        iom     = 1'b0;
        if (r_state != S_IDLE) begin
            busy  = 1'b1;
            bus_a = w_bus_a;
            dtr   = r_we;
            iom   = r_iom;
            // Write data stays on the bus through T4 for hold time.
            if (r_we) begin
                ad_o  = w_wbyte;
                ad_oe = 1'b1;
            end
        end
        unique case (r_state)
            S_IDLE: begin
                if (req)
                    w_next = S_T1;
            end
            S_T1: begin
                w_next = S_T2;
                ale    = 1'b1;
                ad_o   = w_bus_a[7:0];
                ad_oe  = 1'b1;
            end
            S_T2, S_T3: begin
                den_n = 1'b0;
                if (r_we)
                    wr_n = 1'b0;
                else
                    rd_n = 1'b0;
                if (r_state == S_T2)
                    w_next = S_T3;
                else if (ready || w_to_hit)
                    w_next = S_T4;
            end
            S_T4: begin
                done    = w_last || w_to;
                timeout = w_to;
                w_next  = (w_last || w_to) ? S_IDLE : S_T1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_adr   <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_bop   <= 1'b0;
            r_iom   <= 1'b0;
            r_idx   <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == S_IDLE && req) begin
                r_adr   <= adr;
                r_wdata <= wdata;
                r_we    <= we;
                r_bop   <= byte_op;
                r_iom   <= io_m;
                r_idx   <= '0;
            end else if (r_state == S_T4) begin
                r_idx <= (w_next == S_T1) ? r_idx + 1'b1 : '0;
            end
            // Byte reads clear the upper bytes in the same load.
            if (w_load && !r_we) begin
                for (int i = 0; i < DATA_BYTES; i++) begin
                    if (r_idx == IW'(i))
                        r_rdata[i*8 +: 8] <= ready ? ad_i : 8'hFF;
                    else if (r_bop)
                        r_rdata[i*8 +: 8] <= 8'h00;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_cycle_unit.sv
// tb_bus_cycle_unit: randomized and directed checks of bus_cycle_unit
// against a cycle-schedule reference model (DATA_BYTES=2, ADDR_W=20).
module tb_bus_cycle_unit;

    localparam int DB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        byte_op = 1'b0;
    logic        io_m = 1'b0;
    logic [19:0] adr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [19:0] bus_a;
    logic [7:0]  ad_o;
    logic        ad_oe;
    logic [7:0]  ad_i = '0;
    logic        ale;
    logic        rd_n;
    logic        wr_n;
    logic        den_n;
    logic        dtr;
    logic        iom;
    logic        ready = 1'b1;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] mdl_rdata = '0;

    bus_cycle_unit #(
        .DATA_BYTES (DB),
        .ADDR_W     (20),
        .TIMEOUT_CYC(15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .we      (we),
        .byte_op (byte_op),
        .io_m    (io_m),
        .adr     (adr),
        .wdata   (wdata),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done),
        .timeout (timeout),
        .bus_a   (bus_a),
        .ad_o    (ad_o),
        .ad_oe   (ad_oe),
        .ad_i    (ad_i),
        .ale     (ale),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .den_n   (den_n),
        .dtr     (dtr),
        .iom     (iom),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] ctl_now();
        return {ale, rd_n, wr_n, den_n, dtr, iom, ad_oe, busy, done, timeout};
    endfunction

    // Idle bus: only dtr and the strobes' inactive levels are high.
    localparam logic [9:0] CTL_IDLE = 10'b0111100000;

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, 32'(ctl_now()), 32'(CTL_IDLE));
        chk({tag, "_bus_a"}, 32'(bus_a), 32'h0);
        chk({tag, "_ad_o"}, 32'(ad_o), 32'h0);
    endtask

    // Runs one transfer from an IDLE cycle. The expected schedule is built
    // from the phase rules: per byte T1, T2, (waits+1) x T3, T4.
    // rb holds the byte returned on the final T3 of each byte cycle.
    task automatic xfer(input logic w, input logic bop, input logic io,
                        input logic [19:0] a, input logic [15:0] wd,
                        input logic [15:0] rb, input logic [7:0] wt,
                        output int done_at);
        int ph_q[$];
        int bi_q[$];
        bit rl_q[$];
        int nb;
        int p;
        int b;
        bit s23;
        bit lastb;
        logic [19:0] ba;
        logic [9:0] e_ctl;
        nb = bop ? 1 : DB;
        for (int i = 0; i < nb; i++) begin
            ph_q.push_back(1); bi_q.push_back(i); rl_q.push_back(0);
            ph_q.push_back(2); bi_q.push_back(i); rl_q.push_back(0);
            for (int k = 0; k <= int'(wt[i*4 +: 4]); k++) begin
                ph_q.push_back(3); bi_q.push_back(i);
                rl_q.push_back(k == int'(wt[i*4 +: 4]));
            end
            ph_q.push_back(4); bi_q.push_back(i); rl_q.push_back(0);
        end
        req = 1'b1;
        we = w;
        byte_op = bop;
        io_m = io;
        adr = a;
        wdata = wd;
        @(posedge clk);
        #1;
        we = ~w;
        byte_op = ~bop;
        io_m = ~io;
        adr = 20'($urandom);
        wdata = 16'($urandom);
        done_at = -1;
        for (int c = 0; c < ph_q.size(); c++) begin
            p = ph_q[c];
            b = bi_q[c];
            lastb = (b == nb - 1);
            ready = (p == 3) ? rl_q[c] : 1'($urandom);
            ad_i = (p == 3 && rl_q[c]) ? rb[b*8 +: 8] : 8'($urandom);
            s23 = (p == 2 || p == 3);
            ba = a + 20'(b);
            e_ctl = {p == 1, !(s23 && !w), !(s23 && w), !s23, w, io,
                     (p == 1) || w, 1'b1, (p == 4) && lastb, 1'b0};
            chk("ctl", 32'(ctl_now()), 32'(e_ctl));
            chk("bus_a", 32'(bus_a), 32'(ba));
            if (p == 1)
                chk("ad_o_adr", 32'(ad_o), 32'(ba[7:0]));
            else if (w)
                chk("ad_o_dat", 32'(ad_o), 32'(wd[b*8 +: 8]));
            if (done && done_at < 0)
                done_at = c + 1;
            @(posedge clk);
            #1;
        end
        if (!w) begin
            for (int i = 0; i < nb; i++)
                mdl_rdata[i*8 +: 8] = rb[i*8 +: 8];
            if (bop)
                mdl_rdata[15:8] = 8'h00;
        end
        chk("done_at", 32'(done_at), 32'(ph_q.size()));
        chk("idle_busy", 32'(busy), 32'h0);
        chk("rdata", 32'(rdata), 32'(mdl_rdata));
    endtask

    initial begin
        int d;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("rst");
        chk("rst_rdata", 32'(rdata), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // word read, ready=1
        xfer(1'b0, 1'b0, 1'b0, 20'h12345, 16'h0, 16'hBBAA, 8'h00, d);
        chk("wrd_rd_cyc", 32'(d), 32'd8);
        chk("wrd_rd_data", 32'(rdata), 32'hBBAA);
        req = 1'b0;
        chk_idle("gap1");
        @(posedge clk);
        #1;

        // word write
        xfer(1'b1, 1'b0, 1'b1, 20'h00400, 16'hBEEF, 16'h0, 8'h00, d);
        chk("wrd_wr_cyc", 32'(d), 32'd8);
        chk("wr_keeps_rdata", 32'(rdata), 32'hBBAA);

        // byte read with 3 wait states, back-to-back (req stays high)
        xfer(1'b0, 1'b1, 1'b0, 20'h00777, 16'h0, 16'h1234, 8'h03, d);
        chk("byte_rd_cyc", 32'(d), 32'd7);
        chk("byte_rd_hi", 32'(rdata[15:8]), 32'h0);
        chk("byte_rd_lo", 32'(rdata[7:0]), 32'h34);

        // address wrap
        xfer(1'b0, 1'b0, 1'b0, 20'hFFFFF, 16'h0, 16'h5A3C, 8'h10, d);
        chk("wrap_cyc", 32'(d), 32'd9);

        // randomized transfers with random idle gaps
        for (int n = 0; n < 24; n++) begin
            xfer(1'($urandom), 1'($urandom), 1'($urandom), 20'($urandom),
                 16'($urandom), 16'($urandom),
                 {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))}, d);
            if ($urandom_range(0, 1) == 0) begin
                req = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    chk_idle("rnd_gap");
                    @(posedge clk);
                    #1;
                end
            end
        end

        // reset during write T2
        req = 1'b0;
        @(posedge clk);
        #1;
        req = 1'b1;
        we = 1'b1;
        byte_op = 1'b0;
        io_m = 1'b1;
        adr = 20'h0ABCD;
        wdata = 16'h1357;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t2_wr_n", 32'(wr_n), 32'h0);
        rst = 1'b0;
        #1;
        chk_idle("mid_rst");
        chk("mid_rst_rdata", 32'(rdata), 32'h0);
        mdl_rdata = '0;
        req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        xfer(1'b0, 1'b0, 1'b0, 20'h00010, 16'h0, 16'hC0DE, 8'h21, d);
        chk("post_rst_cyc", 32'(d), 32'd11);

`ifdef BUS_TIMEOUT_EN
        // ready stuck low: abort after 15 wait cycles, no second byte
        req = 1'b0;
        @(posedge clk);
        #1;
        req = 1'b1;
        we = 1'b0;
        byte_op = 1'b0;
        adr = 20'h00200;
        ready = 1'b0;
        @(posedge clk);
        #1;
        req = 1'b0;
        d = -1;
        for (int c = 1; c <= 30 && d < 0; c++) begin
            chk("to_bus_a", 32'(bus_a), 32'h00200);
            if (done) begin
                d = c;
                chk("to_flag", 32'(timeout), 32'h1);
            end
            @(posedge clk);
            #1;
        end
        chk("to_cyc", 32'(d), 32'd18);
        chk("to_busy", 32'(busy), 32'h0);
        chk("to_rdata", 32'(rdata[7:0]), 32'hFF);
        ready = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
